scale_mux_arb: RTL and testbench
================================

Name: scale_mux_arb

Overview:
- Parametrised, registered successor to the scale_mux family.
- Selects one of NCH WIDTH-bit input channels onto a single output stream using valid/ready handshakes.
- Two modes: explicit select, as in scale_mux, or round-robin arbitration.
- The output is one registered stage with full throughput; it sits between multi-source producers and a single downstream consumer.

Parameters:
- WIDTH, 8, data width per channel.
- NCH, 4, number of input channels (2..16).
- SELW, $clog2(NCH) (minimum 1), width of sel and out_ch; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NCH  per-channel valid.
- in_ready  out  NCH  per-channel ready (combinational).
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SELW  channel index used in fixed mode.
- out_data  out  WIDTH  registered output data.
- out_valid  out  1  registered output valid.
- out_ready  in  1  downstream ready.
- out_ch  out  SELW  index of the channel that supplied out_data.
- sel_err  out  1  sticky flag: sel was out of range or contained X/Z.

Behaviour:
- Reset (rst_n low at a clk edge): out_valid=0, out_data=0, out_ch=0, sel_err=0, rr pointer=0.
  - in_ready is all zeros while rst_n is low.
  - Reset mid-transfer drops the held beat; no partial state survives.
- Load condition: load = !out_valid || out_ready.
  - in_ready[g] = load && grant_valid && (i==g). Only the granted channel sees ready.
  - A beat transfers on channel i when in_valid[i] && in_ready[i].
- Latency:
  - Data accepted at edge N appears on out_data with out_valid=1 after edge N.
  - Back-to-back transfers run at 1 beat/cycle while out_ready stays 1.
  - With out_ready=0 and out_valid=1, the output holds stable and all in_ready are 0.
- Fixed mode (mode=0):
  - The grant is sel when sel<NCH and in_valid[sel]=1; otherwise there is no grant.
  - sel>=NCH: no grant, sel_err set.
  - Simulation only: if sel contains X/Z while mode=0, sel_err is set and there is no grant.
  - Covers the scale_mux case where sel is driven to 'bZ.
  - sel_err is cleared only by reset.
- Round-robin mode (mode=1):
  - Search starts at ptr and wraps modulo NCH; the grant is the first channel with in_valid=1.
  - On each transfer, ptr <= (granted+1) mod NCH. Wrap-around: from NCH-1 the pointer goes to 0.
  - ptr is unchanged when there is no transfer, including during stalls.
  - sel is ignored and sel_err is not updated.
- Mode change:
  - Takes effect on the next grant evaluation.
  - The held output beat is unaffected.
  - ptr retains its value across mode=0 periods.
- out_ch is registered with out_data and equals the index of the granted channel.
- No valid inputs: out_valid deasserts once the held beat is consumed (out_ready=1).
- Simultaneous pop and push: when out_ready=1 and a new grant exists in the same cycle, the new beat replaces the old one. There is no bubble.

Decomposition:
- Package scale_mux_pkg:
  - mode encoding constants MODE_FIXED=1'b0 and MODE_RR=1'b1.
  - function rr_pick(valid, ptr) returning {found, idx}, parametrised through the NCH argument width.
- Sub-module scale_mux_rr_arb holds the pointer register and the grant logic.
- The top level holds the output register, the in_ready fan-out and sel checking.

Test Plan:
- Fixed mode, WIDTH=8, NCH=4, sel=2, in_data ch2=8'h0C, in_valid=4'b0100, out_ready=1 -> one cycle later out_data=8'h0C, out_ch=2, out_valid=1; in_ready=4'b0100.
- Fixed mode, sel=2, in_valid=4'b0011 -> no grant, in_ready=0, out_valid stays 0, sel_err stays 0.
- Fixed mode, sel driven 2'bzz then 2'b01 -> sel_err=1 and stays 1 after sel becomes valid; ch1 data then passes normally.
- Round-robin, all in_valid=1, out_ready=1 for 6 cycles -> out_ch sequence 0,1,2,3,0,1; throughput 1 beat/cycle.
- Round-robin, out_ready=0 for 3 cycles mid-stream -> out_data/out_ch held, in_ready=0, ptr unchanged; on release the sequence resumes with no loss and no duplication.
- rst_n=0 for one cycle while out_valid=1 and out_ready=0 -> after the edge out_valid=0, out_ch=0, sel_err=0; the next round-robin grant starts at ch0.

Source files
------------

// File: rtl/scale_mux_pkg.sv
// Shared mode encodings and the round-robin search used by the scale_mux_arb family.
package scale_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int MAX_NCH  = 16;
  localparam int MAX_SELW = 4;

  typedef struct packed {
    logic                found;
    logic [MAX_SELW-1:0] idx;
  } rr_pick_t;

  // First valid channel at or after ptr, wrapping modulo nch. Walking the
  // offsets from high to low lets the smallest offset overwrite the result.
  function automatic rr_pick_t rr_pick(input logic [MAX_NCH-1:0]  valid,
                                       input logic [MAX_SELW-1:0] ptr,
                                       input int                  nch);
    rr_pick_t            res;
    logic [MAX_SELW-1:0] idx;
    res = '0;
    for (int k = MAX_NCH - 1; k >= 0; k--) begin
      if (k < nch) begin
        idx = MAX_SELW'((int'(ptr) + k) % nch);
        if (valid[idx]) begin
          res.found = 1'b1;
          res.idx   = idx;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/scale_mux_rr_arb.sv
// Grant logic for scale_mux_arb: fixed select or round-robin, plus the rr pointer.
module scale_mux_rr_arb
  import scale_mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic            sel_ok,
  input  logic [NCH-1:0]  in_valid,
  input  logic            advance,
  output logic            grant_valid,
  output logic [SELW-1:0] grant_idx
);

  localparam int NPAD = 1 << SELW;

  logic [SELW-1:0] ptr_q, ptr_d;
  logic [NPAD-1:0] valid_pad;
  rr_pick_t        pick;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    valid_pad   = NPAD'(in_valid);
    pick        = rr_pick(MAX_NCH'(in_valid), MAX_SELW'(ptr_q), NCH);
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (mode == MODE_RR) begin
      grant_valid = pick.found;
      for (int i = 0; i < NCH; i++) begin
        if (pick.idx == MAX_SELW'(i)) grant_idx = SELW'(i);
      end
    end else if (sel_ok) begin
      grant_valid = valid_pad[sel];
      grant_idx   = sel;
    end
  end

  // Pointer only moves on an accepted round-robin beat, so it survives stalls
  // and fixed-mode periods untouched.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && mode == MODE_RR) begin
      ptr_d = (grant_idx == SELW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/scale_mux_arb.sv
// NCH-to-1 valid/ready stream mux with fixed-select or round-robin arbitration
// and a single full-throughput registered output stage.
module scale_mux_arb
  import scale_mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  localparam int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch,
  output logic                 sel_err
);

  logic             sel_x, sel_ok;
  logic             load, xfer;
  logic             grant_valid;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_ch_q,    out_ch_d;
  logic             sel_err_q,   sel_err_d;

  // X/Z on sel only exists in a four-state simulator; hardware sees a known value.
  always_comb begin
    sel_x  = $isunknown(sel);
    sel_ok = !sel_x && (int'(sel) < NCH);
  end

  scale_mux_rr_arb #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .sel         (sel),
    .sel_ok      (sel_ok),
    .in_valid    (in_valid),
    .advance     (xfer),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    load       = !out_valid_q || out_ready;
    xfer       = rst_n && load && grant_valid;
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = xfer;
      end
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    sel_err_d   = sel_err_q || (mode == MODE_FIXED && !sel_ok);
    // A pop with a waiting grant loads the new beat in the same cycle.
    if (load) begin
      out_valid_d = grant_valid;
      if (grant_valid) begin
        out_data_d = grant_data;
        out_ch_d   = grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_scale_mux_arb.sv
// Self-checking bench for scale_mux_arb: directed scenarios plus a randomized
// run against a transaction-level model of the mux.
module tb_scale_mux_arb;
  import scale_mux_pkg::*;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SELW  = 2;
  localparam int NCH3  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid, in_ready;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid, out_ready;
  logic [SELW-1:0]      out_ch;
  logic                 sel_err;

  logic [NCH3*WIDTH-1:0] in_data3;
  logic [NCH3-1:0]       in_valid3, in_ready3;
  logic                  mode3;
  logic [1:0]            sel3;
  logic [WIDTH-1:0]      out_data3;
  logic                  out_valid3, out_ready3;
  logic [1:0]            out_ch3;
  logic                  sel_err3;

  scale_mux_arb #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .sel_err(sel_err)
  );

  // Non-power-of-two instance so an out-of-range sel can actually be driven.
  scale_mux_arb #(.WIDTH(WIDTH), .NCH(NCH3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_ch(out_ch3), .sel_err(sel_err3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the main instance: the beat held at the output plus the rr pointer.
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic [SELW-1:0]  m_ch;
  logic             m_err;
  int               m_ptr;

  function automatic logic sel_usable();
    return !$isunknown(sel) && (int'(sel) < NCH);
  endfunction

  // Returns the channel that would be granted this cycle, -1 for none.
  function automatic int model_grant();
    int c;
    if (mode == MODE_RR) begin
      for (int k = 0; k < NCH; k++) begin
        c = (m_ptr + k) % NCH;
        if (in_valid[SELW'(c)]) return c;
      end
      return -1;
    end
    if (!sel_usable()) return -1;
    return in_valid[sel] ? int'(sel) : -1;
  endfunction

  function automatic logic [NCH-1:0] model_ready();
    int g;
    g = model_grant();
    if (!rst_n || !(!m_valid || out_ready) || g < 0) return '0;
    return NCH'(1) << g;
  endfunction

  task automatic tick();
    int g;
    if (!rst_n) begin
      m_valid = 1'b0; m_data = '0; m_ch = '0; m_err = 1'b0; m_ptr = 0;
    end else begin
      g = model_grant();
      if (mode == MODE_FIXED && !sel_usable()) m_err = 1'b1;
      if (!m_valid || out_ready) begin
        m_valid = (g >= 0);
        if (g >= 0) begin
          m_data = in_data[g*WIDTH +: WIDTH];
          m_ch   = SELW'(g);
          if (mode == MODE_RR) m_ptr = (g + 1) % NCH;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = MODE_FIXED; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b1;
    mode3 = MODE_FIXED; sel3 = '0; in_valid3 = '0; in_data3 = '0; out_ready3 = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== '0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    tick();
    n_tests++;
    if ({out_valid, out_data, out_ch, sel_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h ch=%0d err=%b expected all 0",
               out_valid, out_data, out_ch, sel_err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fixed_basic();
    mode = MODE_FIXED; sel = 2'd2; in_data = $urandom; in_data[23:16] = 8'h0C;
    in_valid = 4'b0100; out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 4'b0100) begin
      n_fail++; $display("FAIL fixed_in_ready: got %b expected 0100", in_ready);
    end
    tick();
    n_tests++;
    if ({out_valid, out_data, out_ch, sel_err} !== {1'b1, 8'h0C, 2'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL fixed_out: got v=%b d=%h ch=%0d err=%b expected v=1 d=0c ch=2 err=0",
               out_valid, out_data, out_ch, sel_err);
    end
  endtask

  task automatic test_fixed_nogrant();
    sel = 2'd2; in_valid = 4'b0011; in_data = $urandom;
    #1;
    n_tests++;
    if (in_ready !== '0) begin
      n_fail++; $display("FAIL nogrant_in_ready: got %b expected 0000", in_ready);
    end
    tick();
    n_tests++;
    if ({out_valid, sel_err} !== 2'b00) begin
      n_fail++; $display("FAIL nogrant_out: got v=%b err=%b expected v=0 err=0", out_valid, sel_err);
    end
  endtask

  task automatic test_sel_x();
    sel = 2'bzz; in_valid = 4'b0010; in_data = $urandom; in_data[15:8] = 8'h5A;
    #1;
    n_tests++;
    if (in_ready !== model_ready()) begin
      n_fail++; $display("FAIL selx_in_ready: got %b expected %b", in_ready, model_ready());
    end
    tick();
    n_tests++;
    if (sel_err !== m_err) begin
      n_fail++; $display("FAIL selx_err: got %b expected %b", sel_err, m_err);
    end
    sel = 2'b01;
    #1;
    n_tests++;
    if (in_ready !== 4'b0010) begin
      n_fail++; $display("FAIL selx_recover_ready: got %b expected 0010", in_ready);
    end
    tick();
    n_tests++;
    if ({out_valid, out_data, out_ch, sel_err} !== {1'b1, 8'h5A, 2'd1, m_err}) begin
      n_fail++;
      $display("FAIL selx_recover_out: got v=%b d=%h ch=%0d err=%b expected v=1 d=5a ch=1 err=%b",
               out_valid, out_data, out_ch, sel_err, m_err);
    end
  endtask

  task automatic test_sel_range();
    mode3 = MODE_FIXED; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1; in_data3 = $urandom;
    #1;
    n_tests++;
    if (in_ready3 !== 3'b000) begin
      n_fail++; $display("FAIL range_in_ready: got %b expected 000", in_ready3);
    end
    tick();
    n_tests++;
    if ({out_valid3, sel_err3} !== 2'b01) begin
      n_fail++; $display("FAIL range_err: got v=%b err=%b expected v=0 err=1", out_valid3, sel_err3);
    end
    sel3 = 2'd1; in_data3[15:8] = 8'hA5;
    #1;
    n_tests++;
    if (in_ready3 !== 3'b010) begin
      n_fail++; $display("FAIL range_recover_ready: got %b expected 010", in_ready3);
    end
    tick();
    n_tests++;
    if ({out_valid3, out_data3, out_ch3, sel_err3} !== {1'b1, 8'hA5, 2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL range_sticky: got v=%b d=%h ch=%0d err=%b expected v=1 d=a5 ch=1 err=1",
               out_valid3, out_data3, out_ch3, sel_err3);
    end
    in_valid3 = '0;
  endtask

  task automatic test_rr_sequence();
    int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
    mode = MODE_RR; in_valid = '1; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data = $urandom;
      #1;
      n_tests++;
      if (in_ready !== (NCH'(1) << exp_seq[k])) begin
        n_fail++; $display("FAIL rr_ready[%0d]: got %b expected ch%0d", k, in_ready, exp_seq[k]);
      end
      tick();
      n_tests++;
      if ({out_valid, out_ch, out_data} !== {1'b1, SELW'(exp_seq[k]), m_data}) begin
        n_fail++;
        $display("FAIL rr_seq[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h",
                 k, out_valid, out_ch, out_data, exp_seq[k], m_data);
      end
    end
  endtask

  task automatic test_rr_stall();
    logic [WIDTH-1:0] held_data;
    logic [SELW-1:0]  held_ch;
    in_data = $urandom;
    tick();
    held_data = out_data; held_ch = out_ch;
    n_tests++;
    if (held_ch !== 2'd2) begin
      n_fail++; $display("FAIL stall_pre_ch: got %0d expected 2", held_ch);
    end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data = $urandom;
      #1;
      n_tests++;
      if (in_ready !== '0) begin
        n_fail++; $display("FAIL stall_ready[%0d]: got %b expected 0000", k, in_ready);
      end
      tick();
      n_tests++;
      if ({out_valid, out_data, out_ch} !== {1'b1, held_data, held_ch}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%b d=%h ch=%0d expected v=1 d=%h ch=%0d",
                 k, out_valid, out_data, out_ch, held_data, held_ch);
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = $urandom;
      tick();
      n_tests++;
      if ({out_valid, out_ch, out_data} !== {1'b1, SELW'((int'(held_ch) + 1 + k) % NCH), m_data}) begin
        n_fail++;
        $display("FAIL stall_resume[%0d]: got v=%b ch=%0d d=%h expected ch=%0d d=%h",
                 k, out_valid, out_ch, out_data, (int'(held_ch) + 1 + k) % NCH, m_data);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; mode3 = MODE_FIXED; sel3 = 2'd3;
    tick();
    n_tests++;
    if ({out_valid, sel_err3} !== 2'b11) begin
      n_fail++; $display("FAIL mid_precond: got v=%b err3=%b expected v=1 err3=1", out_valid, sel_err3);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, in_ready3} !== '0) begin
      n_fail++; $display("FAIL mid_ready: got %b/%b expected all 0", in_ready, in_ready3);
    end
    tick();
    n_tests++;
    if ({out_valid, out_data, out_ch, sel_err, sel_err3} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b d=%h ch=%0d err=%b err3=%b expected all 0",
               out_valid, out_data, out_ch, sel_err, sel_err3);
    end
    rst_n = 1'b1; sel3 = '0; mode = MODE_RR; in_valid = '1; out_ready = 1'b1; in_data = $urandom;
    #1;
    n_tests++;
    if (in_ready !== 4'b0001) begin
      n_fail++; $display("FAIL mid_first_ready: got %b expected 0001", in_ready);
    end
    tick();
    n_tests++;
    if ({out_valid, out_ch} !== {1'b1, 2'd0}) begin
      n_fail++; $display("FAIL mid_first_grant: got v=%b ch=%0d expected v=1 ch=0", out_valid, out_ch);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      sel       = SELW'($urandom);
      in_valid  = NCH'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      #1;
      n_tests++;
      if (in_ready !== model_ready()) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", k, in_ready, model_ready());
      end
      tick();
      n_tests++;
      if ({out_valid, out_data, out_ch, sel_err} !== {m_valid, m_data, m_ch, m_err}) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: got v=%b d=%h ch=%0d err=%b expected v=%b d=%h ch=%0d err=%b",
                 k, out_valid, out_data, out_ch, sel_err, m_valid, m_data, m_ch, m_err);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    m_valid = 1'b0; m_data = '0; m_ch = '0; m_err = 1'b0; m_ptr = 0;
    test_reset();
    test_fixed_basic();
    test_fixed_nogrant();
    test_sel_x();
    test_sel_range();
    reset_dut();
    test_rr_sequence();
    test_rr_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
